// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// UNROLL bits per cycle, signed ops via magnitudes plus a final sign-fix cycle.
module muldiv_iter #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_by_zero_o
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGNFIX, S_DONE} state_t;

  state_t             r_state, w_next;
  logic               r_div, r_sa, r_sb;
  logic [WIDTH-1:0]   r_hi, r_lo, r_b;
  logic [CW-1:0]      r_cnt;
  logic               r_ready, r_dbz;
  logic [2*WIDTH-1:0] r_result;

  logic               w_accept, w_zero, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH-1:0]   w_hi_n, w_lo_n;
  logic [WIDTH:0]     w_t;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic [2*WIDTH-1:0] w_final;

  assign w_accept = (r_state == S_IDLE) && start_i && !annul_i;
  assign w_zero   = op_i[1] && (opdata2_i == '0);
  assign w_a_neg  = !op_i[0] && opdata1_i[WIDTH-1];
  assign w_b_neg  = !op_i[0] && opdata2_i[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -opdata1_i : opdata1_i;
  assign w_b_mag  = w_b_neg ? -opdata2_i : opdata2_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (annul_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (start_i) w_next = w_zero ? S_DONE : S_CALC;
        S_CALC:    if (r_cnt == CW'(N - 1)) w_next = S_SIGNFIX;
        S_SIGNFIX: w_next = S_DONE;
        S_DONE:    if (!start_i) w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Divide: {hi,lo} = {remainder, dividend->quotient}. Multiply: {hi,lo} =
  // {partial product, multiplier->low product}; carry shifts back into hi.
  always_comb begin
    w_hi_n = r_hi;
    w_lo_n = r_lo;
    w_t    = '0;
    for (int k = 0; k < UNROLL; k++) begin
      if (r_div) begin
        w_t    = {w_hi_n, w_lo_n[WIDTH-1]};
        w_lo_n = {w_lo_n[WIDTH-2:0], 1'b0};
        if (w_t >= {1'b0, r_b}) begin
          w_t       = w_t - {1'b0, r_b};
          w_lo_n[0] = 1'b1;
        end
        w_hi_n = w_t[WIDTH-1:0];
      end else begin
        w_t    = {1'b0, w_hi_n} + (w_lo_n[0] ? {1'b0, r_b} : '0);
        w_lo_n = {w_t[0], w_lo_n[WIDTH-1:1]};
        w_hi_n = w_t[WIDTH:1];
      end
    end
  end

  // Unsigned ops latch both sign bits as 0, so they pass through unchanged.
  always_comb begin
    w_quo   = (r_sa ^ r_sb) ? -r_lo : r_lo;
    w_rem   = r_sa ? -r_hi : r_hi;
    w_final = {w_rem, w_quo};
    if (!r_div) w_final = (r_sa ^ r_sb) ? -{r_hi, r_lo} : {r_hi, r_lo};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div    <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_dbz    <= 1'b0;
      r_result <= '0;
    end else begin
      // ready lags DONE entry by one cycle and drops on the exit edge
      r_ready <= (r_state == S_DONE) && (w_next == S_DONE);
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_div <= op_i[1];
          r_sa  <= w_a_neg;
          r_sb  <= w_b_neg;
          r_cnt <= '0;
          r_hi  <= '0;
          r_dbz <= w_zero;
          r_lo  <= op_i[1] ? w_a_mag : w_b_mag;
          r_b   <= op_i[1] ? w_b_mag : w_a_mag;
          if (w_zero) r_result <= {opdata1_i, {WIDTH{1'b1}}};
        end
        S_CALC: if (!annul_i) begin
          r_hi  <= w_hi_n;
          r_lo  <= w_lo_n;
          r_cnt <= r_cnt + CW'(1);
        end
        S_SIGNFIX: if (!annul_i) r_result <= w_final;
        default: ;
      endcase
    end
  end

  assign busy_o        = (r_state == S_CALC) || (r_state == S_SIGNFIX);
  assign ready_o       = r_ready;
  assign result_o      = r_result;
  assign div_by_zero_o = r_dbz;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: UNROLL=1 and UNROLL=4 instances, shared operands.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst1, rst4, start1, start4, annul;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy1, ready1, dbz1, busy4, ready4, dbz4;
  logic [63:0] res1, res4;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(32), .UNROLL(1)) dut1 (
    .clk(clk), .reset(rst1), .start_i(start1), .annul_i(annul), .op_i(op),
    .opdata1_i(a), .opdata2_i(b), .busy_o(busy1), .ready_o(ready1),
    .result_o(res1), .div_by_zero_o(dbz1));

  muldiv_iter #(.WIDTH(32), .UNROLL(4)) dut4 (
    .clk(clk), .reset(rst4), .start_i(start4), .annul_i(annul), .op_i(op),
    .opdata1_i(a), .opdata2_i(b), .busy_o(busy4), .ready_o(ready4),
    .result_o(res4), .div_by_zero_o(dbz4));

  // Raises start and waits for ready; edges = index of the posedge after
  // which ready was first seen (start sampled at edge 0), -1 on timeout.
  task automatic run_op(input bit sel, input logic [1:0] o, input logic [31:0] x, y,
                        output int edges, output logic [63:0] res, output logic dbz);
    op = o; a = x; b = y;
    if (sel) start4 = 1'b1; else start1 = 1'b1;
    edges = -1;
    for (int n = 1; n <= 300 && edges < 0; n++) begin
      @(negedge clk);
      if ((sel ? ready4 : ready1) === 1'b1) edges = n - 1;
    end
    res = sel ? res4 : res1;
    dbz = sel ? dbz4 : dbz1;
  endtask

  task automatic release_op(input bit sel);
    if (sel) start4 = 1'b0; else start1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst1 = 1'b1; rst4 = 1'b1; start1 = 1'b0; start4 = 1'b0; annul = 1'b0;
    op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy1, ready1, dbz1, res1} !== 67'd0) begin
      errors++; $display("FAIL reset_u1 got=%h exp=0", {busy1, ready1, dbz1, res1});
    end
    checks++;
    if ({busy4, ready4, dbz4, res4} !== 67'd0) begin
      errors++; $display("FAIL reset_u4 got=%h exp=0", {busy4, ready4, dbz4, res4});
    end
    rst1 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_udiv;
    int e; logic [63:0] r; logic z;
    run_op(0, 2'b11, 32'd100, 32'd7, e, r, z);
    checks++;
    if (e !== 34) begin errors++; $display("FAIL udiv_latency got=%0d exp=34", e); end
    checks++;
    if (r !== {32'd2, 32'd14}) begin errors++; $display("FAIL udiv_result got=%h exp=%h", r, {32'd2, 32'd14}); end
    checks++;
    if (z !== 1'b0) begin errors++; $display("FAIL udiv_dbz got=%b exp=0", z); end
    @(negedge clk);
    checks++;
    if ({ready1, res1} !== {1'b1, 32'd2, 32'd14}) begin
      errors++; $display("FAIL udiv_hold got=%h exp=%h", {ready1, res1}, {1'b1, 32'd2, 32'd14});
    end
    start1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy1, ready1} !== 2'b00) begin errors++; $display("FAIL udiv_drop got=%b exp=00", {busy1, ready1}); end
    checks++;
    if (res1 !== {32'd2, 32'd14}) begin errors++; $display("FAIL udiv_keep got=%h exp=%h", res1, {32'd2, 32'd14}); end
  endtask

  task automatic test_sdiv;
    int e; logic [63:0] r; logic z;
    run_op(0, 2'b10, 32'hFFFF_FFF9, 32'd2, e, r, z);
    release_op(0);
    checks++;
    if (r !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL sdiv_neg got=%h exp=ffffffff_fffffffd", r); end
    run_op(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, e, r, z);
    release_op(0);
    checks++;
    if (r !== 64'h00000000_80000000) begin errors++; $display("FAIL sdiv_ovf got=%h exp=00000000_80000000", r); end
    checks++;
    if (e !== 34) begin errors++; $display("FAIL sdiv_latency got=%0d exp=34", e); end
  endtask

  task automatic test_mul;
    int e; logic [63:0] r; logic z;
    run_op(0, 2'b00, 32'hFFFF_FFFD, 32'd5, e, r, z);
    release_op(0);
    checks++;
    if (r !== 64'hFFFFFFFF_FFFFFFF1) begin errors++; $display("FAIL smul_neg got=%h exp=ffffffff_fffffff1", r); end
    checks++;
    if (e !== 34) begin errors++; $display("FAIL smul_latency got=%0d exp=34", e); end
    run_op(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, r, z);
    release_op(0);
    checks++;
    if (r !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL umul_max got=%h exp=fffffffe_00000001", r); end
    run_op(0, 2'b00, 32'h8000_0000, 32'h8000_0000, e, r, z);
    release_op(0);
    checks++;
    if (r !== 64'h40000000_00000000) begin errors++; $display("FAIL smul_min got=%h exp=40000000_00000000", r); end
  endtask

  task automatic test_div_zero;
    int e; logic [63:0] r; logic z;
    run_op(0, 2'b11, 32'h0000_1234, 32'd0, e, r, z);
    release_op(0);
    checks++;
    if (e !== 1) begin errors++; $display("FAIL dz_latency got=%0d exp=1", e); end
    checks++;
    if (z !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b exp=1", z); end
    checks++;
    if (r !== 64'h00001234_FFFFFFFF) begin errors++; $display("FAIL dz_result got=%h exp=00001234_ffffffff", r); end
    run_op(0, 2'b11, 32'd100, 32'd7, e, r, z);
    release_op(0);
    checks++;
    if (z !== 1'b0) begin errors++; $display("FAIL dz_clear got=%b exp=0", z); end
  endtask

  task automatic test_annul;
    int e; logic [63:0] r; logic z; bit seen;
    op = 2'b11; a = 32'd1000; b = 32'd3; start1 = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy1, ready1} !== 2'b00) begin errors++; $display("FAIL annul_busy got=%b exp=00", {busy1, ready1}); end
    annul = 1'b0; start1 = 1'b0;
    seen = 1'b0;
    repeat (50) begin @(negedge clk); if (ready1 !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL annul_ready got=1 exp=0"); end
    checks++;
    if (res1 !== {32'd2, 32'd14}) begin errors++; $display("FAIL annul_keep got=%h exp=%h", res1, {32'd2, 32'd14}); end
    run_op(0, 2'b11, 32'd45, 32'd9, e, r, z);
    release_op(0);
    checks++;
    if ({e, r} !== {32'd34, 32'd0, 32'd5}) begin
      errors++; $display("FAIL annul_next got=%0d/%h exp=34/%h", e, r, {32'd0, 32'd5});
    end
  endtask

  task automatic test_unroll4;
    int e; logic [63:0] r; logic z;
    run_op(1, 2'b11, 32'd100, 32'd7, e, r, z);
    release_op(1);
    checks++;
    if (e !== 10) begin errors++; $display("FAIL u4_latency got=%0d exp=10", e); end
    checks++;
    if (r !== {32'd2, 32'd14}) begin errors++; $display("FAIL u4_result got=%h exp=%h", r, {32'd2, 32'd14}); end
    op = 2'b11; a = 32'd100; b = 32'd7; start4 = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy4 !== 1'b1) begin errors++; $display("FAIL u4_busy got=%b exp=1", busy4); end
    #2 rst4 = 1'b1;
    #1;
    checks++;
    if ({busy4, ready4, dbz4, res4} !== 67'd0) begin
      errors++; $display("FAIL u4_async_reset got=%h exp=0", {busy4, ready4, dbz4, res4});
    end
    start4 = 1'b0;
    @(negedge clk);
    rst4 = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy4, ready4} !== 2'b00) begin errors++; $display("FAIL u4_idle got=%b exp=00", {busy4, ready4}); end
    run_op(1, 2'b11, 32'd45, 32'd9, e, r, z);
    release_op(1);
    checks++;
    if ({e, r} !== {32'd10, 32'd0, 32'd5}) begin
      errors++; $display("FAIL u4_after_reset got=%0d/%h exp=10/%h", e, r, {32'd0, 32'd5});
    end
  endtask

  initial begin
    test_reset;
    test_udiv;
    test_sdiv;
    test_mul;
    test_div_zero;
    test_annul;
    test_unroll4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit for the execute stage; successor to the fixed 32-bit radix-2 divider.
- Adds configurable operand width and bits retired per cycle (UNROLL).
- Adds iterative signed/unsigned multiply alongside divide.
- Adds a divide-by-zero flag.
- Result is {hi,lo} for the HI/LO register path. The pipeline holds start_i high (stall) until ready_o.

Parameters:
- WIDTH, 32, operand width in bits; must be even and ≥ 4.
- UNROLL, 1, quotient/multiplier bits processed per cycle; legal values 1, 2, 4; must divide WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_i  input  1  request. Sampled in IDLE; held high by the pipeline until ready_o.
- annul_i  input  1  abort current operation (flush/exception).
- op_i  input  2  operation: 00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
- opdata1_i  input  WIDTH  multiplicand / dividend.
- opdata2_i  input  WIDTH  multiplier / divisor.
- busy_o  output  1  high in CALC and SIGNFIX.
- ready_o  output  1  result valid.
- result_o  output  2*WIDTH  mul: full product. div: {remainder, quotient}.
- div_by_zero_o  output  1  current result came from a zero divisor.

Behaviour:
- Reset: state=IDLE; busy_o=0, ready_o=0, result_o=0, div_by_zero_o=0. Reset mid-operation aborts immediately with no residue.
- States: IDLE, CALC, SIGNFIX, DONE. N = WIDTH/UNROLL.
- IDLE:
  - start_i=1 and annul_i=0 latches op_i and the operands.
  - Signed ops store operand absolute values plus sign bits; unsigned ops store raw values.
  - Iteration counter cleared; ready_o=0; div_by_zero_o=0.
  - Divide with opdata2_i==0: go directly to DONE with result_o={opdata1_i, {WIDTH{1'b1}}} and div_by_zero_o=1.
  - All other requests go to CALC.
- CALC, divide:
  - Restoring shift-subtract, UNROLL quotient bits per cycle, on unsigned magnitudes.
- CALC, multiply:
  - Shift-add, UNROLL multiplier bits per cycle, into a 2*WIDTH accumulator.
  - Leave CALC after exactly N cycles.
- SIGNFIX (1 cycle, signed ops only; unsigned ops pass through with values unchanged):
  - Signed mul: negate the product when the operand signs differ.
  - Signed div: negate the quotient when the signs differ; the remainder takes the dividend's sign.
  - Final result is loaded into result_o.
- DONE:
  - ready_o=1; result_o and div_by_zero_o are stable.
  - Stay while start_i=1; return to IDLE the cycle after start_i=0 is sampled.
  - On leaving DONE, ready_o drops; result_o holds its value until the next load.
- Latency: start_i sampled in IDLE at edge 0 → ready_o high after edge N+2. Zero divisor: ready_o high after edge 1.
- annul_i:
  - Priority over everything except reset.
  - In CALC, SIGNFIX or DONE: next state IDLE, ready_o=0, result_o unchanged from its prior value.
  - In IDLE: start is blocked.
- Inputs op_i, opdata1_i and opdata2_i are ignored outside the IDLE sampling edge.
- Arithmetic edge cases:
  - Signed -2^(WIDTH-1) / -1 gives quotient 2^(WIDTH-1) (bit pattern 0x80000000 at 32), remainder 0, no trap.
  - Signed mul of -2^(WIDTH-1) × -2^(WIDTH-1) gives 2^(2*WIDTH-2).
- Any op is accepted in IDLE back-to-back after DONE→IDLE; minimum spacing is one IDLE cycle.

Test Plan:
- WIDTH=32, UNROLL=1: op=11, 100/7 → after 34 cycles ready_o=1, result_o={32'd2, 32'd14}. Held while start_i stays 1; ready_o=0 one cycle after start_i drops.
- op=10, -7/2 → result_o={0xFFFFFFFF, 0xFFFFFFFD}. op=10, 0x80000000/0xFFFFFFFF → {0x00000000, 0x80000000}.
- op=00, -3×5 → 0xFFFFFFFF_FFFFFFF1. op=01, 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE_00000001.
- op=11, 0x1234/0 → ready_o after 1 cycle, div_by_zero_o=1, result_o={0x00001234, 0xFFFFFFFF}. Next normal op clears div_by_zero_o.
- annul_i pulse at CALC cycle 10 → busy_o=0 next cycle, ready_o never asserts, result_o keeps prior value. New start 45/9 then gives {0, 5} after 34 cycles.
- UNROLL=4: 100/7 ready after 10 cycles with identical result. reset asserted at CALC cycle 3 → all outputs 0 asynchronously, IDLE after release.
